// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply/divide unit:
// op codes, FSM state encoding and the default operand width.
package muldiv_pkg;

    localparam int MD_DATA_W = 32;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 shift/add multiply and restoring divide on operand magnitudes,
// with sign fix-up and divide-by-zero override applied to the final step.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic              clock,
    input  logic              load,
    input  logic              load_div,
    input  logic              load_signed,
    input  logic              step,
    input  logic              is_div,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo
);

    // acc: upper product half / partial remainder; mq: multiplier / dividend -> quotient
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mq;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] a_raw;
    logic              neg_q;
    logic              neg_r;
    logic              div_zero;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W-1:0] mul_acc;
    logic [DATA_W-1:0] mul_mq;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W+1:0] div_diff;
    logic              div_take;
    logic [DATA_W-1:0] div_acc;
    logic [DATA_W-1:0] div_mq;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] mq_next;
    logic [2*DATA_W-1:0] prod;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
    endfunction

    always_ff @(posedge clock) begin
        if (load) begin
            acc      <= '0;
            mq       <= mag(src_a, load_signed);
            opb      <= mag(src_b, load_signed);
            a_raw    <= src_a;
            neg_q    <= load_signed & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            neg_r    <= load_signed & src_a[DATA_W-1];
            div_zero <= load_div & (src_b == '0);
        end else if (step) begin
            acc <= acc_next;
            mq  <= mq_next;
        end
    end

    always_comb begin
        mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
        mul_acc   = mul_sum[DATA_W:1];
        mul_mq    = {mul_sum[0], mq[DATA_W-1:1]};

        div_shift = {acc, mq[DATA_W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb};
        div_take  = ~div_diff[DATA_W+1];
        div_acc   = div_take ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
        div_mq    = {mq[DATA_W-2:0], div_take};

        acc_next  = is_div ? div_acc : mul_acc;
        mq_next   = is_div ? div_mq  : mul_mq;
    end

    // Results reflect the step taken this cycle so the last edge can commit them directly
    always_comb begin
        prod = {acc_next, mq_next};
        if (!is_div) begin
            prod   = neg_q ? (~prod + (2*DATA_W)'(1)) : prod;
            res_hi = prod[2*DATA_W-1:DATA_W];
            res_lo = prod[DATA_W-1:0];
        end else if (div_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            res_hi = neg_r ? (~acc_next + DATA_W'(1)) : acc_next;
            res_lo = neg_q ? (~mq_next + DATA_W'(1)) : mq_next;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative HI/LO multiply/divide unit: FSM, iteration counter,
// architectural HI/LO registers and the pipeline stall request.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              abort,
    input  logic              hilo_read,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              stall
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    md_state_t         state;
    md_state_t         state_next;
    logic [CNT_W-1:0]  counter;
    logic              accept;
    logic              accept_mul;
    logic              accept_div;
    logic              last_step;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;

    assign busy       = (state != ST_IDLE);
    assign stall      = busy & (start | hilo_read);
    assign accept     = (state == ST_IDLE) & start & ~abort;
    assign accept_mul = accept & op_is_mul(op);
    assign accept_div = accept & op_is_div(op);
    assign last_step  = busy & ~abort & (counter == CNT_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept_mul) begin
                    state_next = ST_MUL;
                end else if (accept_div) begin
                    state_next = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (abort || last_step) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
        end else if (accept_mul || accept_div) begin
            counter <= CNT_W'(DATA_W);
        end else if (busy) begin
            counter <= abort ? '0 : (counter - CNT_W'(1));
        end
    end

    // HI/LO move only on completion or an accepted MTHI/MTLO
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (last_step) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (accept && (op == MD_MTHI)) begin
            hi <= src_a;
        end else if (accept && (op == MD_MTLO)) begin
            lo <= src_a;
        end
    end

    muldiv_datapath #(
        .DATA_W (DATA_W)
    ) u_datapath (
        .clock       (clock),
        .load        (accept_mul | accept_div),
        .load_div    (accept_div),
        .load_signed (op_is_signed(op)),
        .step        (busy),
        .is_div      (state == ST_DIV),
        .src_a       (src_a),
        .src_b       (src_b),
        .res_hi      (res_hi),
        .res_lo      (res_lo)
    );

endmodule
